// File: rtl/l1_d_lsu_adapter.sv
// Load/store adapter between the core pipeline and the L1 data cache.
// Holds each request across cache stalls, extends sub-word loads and does read-modify-write for sub-word stores.
module l1_d_lsu_adapter #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 5,
  parameter int OFF_W  = 6,
  parameter int TAG_W  = ADDR_W - IDX_W - OFF_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [TAG_W-1:0]  tag_C_L1,
  output logic [IDX_W-1:0]  index_C_L1,
  output logic [OFF_W-1:0]  offset,
  output logic              read_C_L1,
  output logic              write_C_L1,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data_L1_C,
  input  logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [31:0]         write_data_q, write_data_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Little-endian lane merge: only the addressed bytes change, the rest come from the cache word.
  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [15:0] wd,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) begin
      case (a)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (a[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    write_data_d = write_data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    stall_cnt_d  = stall_cnt_q;

    if ((state_q == RD || state_q == WR) && stall && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata[15:0];
          if (misaligned(req_size, req_addr[1:0])) begin
            resp_rdata_d = 32'd0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else if (req_we && req_size == 2'b10) begin
            write_data_d = req_wdata;
            state_d      = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (!stall) begin
          if (we_q) begin
            write_data_d = merge_store(read_data_L1_C, wdata_q, size_q, addr_q[1:0]);
            state_d      = WR;
          end else begin
            resp_rdata_d = extract_load(read_data_L1_C, size_q, addr_q[1:0], unsigned_q);
            resp_err_d   = 1'b0;
            state_d      = RESP;
          end
        end
      end
      WR: begin
        if (!stall) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 16'd0;
      write_data_q <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      write_data_q <= write_data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign read_C_L1  = (state_q == RD);
  assign write_C_L1 = (state_q == WR);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign write_data = write_data_q;
  assign stall_cnt  = stall_cnt_q;
  assign tag_C_L1   = addr_q[ADDR_W-1:IDX_W+OFF_W];
  assign index_C_L1 = addr_q[IDX_W+OFF_W-1:OFF_W];
  assign offset     = {addr_q[OFF_W-1:2], 2'b00};

endmodule

// File: tb/tb_l1_d_lsu_adapter.sv
// Directed bench for l1_d_lsu_adapter: drives core requests and plays the cache side by hand.
module tb_l1_d_lsu_adapter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        reqValid, reqWe, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        reqReady, respValid, respErr;
  logic [31:0] respRdata;
  logic [20:0] tagOut;
  logic [4:0]  indexOut;
  logic [5:0]  offsetOut;
  logic        readStrobe, writeStrobe, stallIn;
  logic [31:0] writeData, readData;
  logic [15:0] stallCnt;

  int checkCount = 0;
  int errorCount = 0;

  int          latency, rdCount, wrCount, addrBad, readyDuring, expStallCnt;
  logic        bothStrobes, gotErr, readyAfter, respAfter;
  logic [31:0] gotRdata, gotWdata, heldRdata;

  l1_d_lsu_adapter dut (
    .clk(clk), .nrst(nrst),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe), .req_size(reqSize),
    .req_unsigned(reqUnsigned), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid), .resp_rdata(respRdata), .resp_err(respErr),
    .tag_C_L1(tagOut), .index_C_L1(indexOut), .offset(offsetOut),
    .read_C_L1(readStrobe), .write_C_L1(writeStrobe), .write_data(writeData),
    .read_data_L1_C(readData), .stall(stallIn), .stall_cnt(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One request, then the cache side is modelled cycle by cycle on the falling edge.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdWord, input int stallCycles);
    int stallLeft;
    stallLeft = stallCycles;
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqSize = size; reqUnsigned = uns;
    reqAddr = addr; reqWdata = wdata; readData = rdWord; stallIn = 1'b0;
    @(posedge clk);
    #1;
    reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 32'hFFFF_FFFF; reqWdata = 32'h5555_5555;
    latency = 0; rdCount = 0; wrCount = 0; addrBad = 0; readyDuring = 0;
    bothStrobes = 1'b0; gotErr = 1'bx; gotRdata = 'x; gotWdata = 'x;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (readStrobe && writeStrobe) bothStrobes = 1'b1;
      if (reqReady) readyDuring++;
      if ((readStrobe || writeStrobe) &&
          (tagOut != addr[31:11] || indexOut != addr[10:6] || offsetOut != {addr[5:2], 2'b00}))
        addrBad++;
      if ((readStrobe || writeStrobe) && stallLeft > 0) begin
        stallIn = 1'b1;
        stallLeft--;
        expStallCnt++;
      end else begin
        stallIn = 1'b0;
        if (readStrobe) rdCount++;
        if (writeStrobe) begin
          wrCount++;
          gotWdata = writeData;
        end
      end
      if (respValid) begin
        latency = n;
        gotRdata = respRdata;
        gotErr = respErr;
        break;
      end
    end
    @(negedge clk);
    stallIn = 1'b0;
    readyAfter = reqReady;
    respAfter = respValid;
    heldRdata = respRdata;
  endtask

  initial begin
    nrst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 32'd0; reqWdata = 32'd0; readData = 32'd0; stallIn = 1'b0; expStallCnt = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, reqReady}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, respValid}, 32'd0);
    checkOutput("rst_strobes", {30'd0, readStrobe, writeStrobe}, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stallCnt}, 32'd0);
    checkOutput("rst_addr_out", {tagOut, indexOut, offsetOut}, 32'd0);
    nrst = 1'b0;

    // lw 0x844, hit
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0844, 32'd0, 32'hDEAD_BEEF, 0);
    checkOutput("lw_latency", latency, 32'd2);
    checkOutput("lw_rdata", gotRdata, 32'hDEAD_BEEF);
    checkOutput("lw_err", {31'd0, gotErr}, 32'd0);
    checkOutput("lw_index", {27'd0, indexOut}, 32'd1);
    checkOutput("lw_offset", {26'd0, offsetOut}, 32'h04);
    checkOutput("lw_tag", {11'd0, tagOut}, 32'd1);
    checkOutput("lw_reads", rdCount, 32'd1);
    checkOutput("lw_writes", wrCount, 32'd0);
    checkOutput("lw_ready_busy", readyDuring, 32'd0);
    checkOutput("lw_ready_after", {31'd0, readyAfter}, 32'd1);
    checkOutput("lw_resp_pulse", {31'd0, respAfter}, 32'd0);
    checkOutput("lw_rdata_held", heldRdata, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0047, 32'd0, 32'h80FF_1234, 0);
    checkOutput("lb_rdata", gotRdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0047, 32'd0, 32'h80FF_1234, 0);
    checkOutput("lbu_rdata", gotRdata, 32'h0000_0080);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0046, 32'd0, 32'h80FF_1234, 0);
    checkOutput("lh_rdata", gotRdata, 32'hFFFF_80FF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0044, 32'd0, 32'h80FF_F234, 0);
    checkOutput("lhu_rdata", gotRdata, 32'h0000_F234);
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h0000_0048, 32'd0, 32'h8000_0001, 0);
    checkOutput("lw_uns_rdata", gotRdata, 32'h8000_0001);

    // sb 0xAA to 0x45 over 0x11223344
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0045, 32'h0000_00AA, 32'h1122_3344, 0);
    checkOutput("sb_latency", latency, 32'd3);
    checkOutput("sb_reads", rdCount, 32'd1);
    checkOutput("sb_writes", wrCount, 32'd1);
    checkOutput("sb_wdata", gotWdata, 32'h1122_AA44);
    checkOutput("sb_rdata", gotRdata, 32'd0);
    checkOutput("sb_both", {31'd0, bothStrobes}, 32'd0);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0046, 32'h0000_BEEF, 32'h1122_3344, 0);
    checkOutput("sh_wdata", gotWdata, 32'hBEEF_3344);
    checkOutput("sh_latency", latency, 32'd3);

    // sw with the cache stalling for five cycles
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0001_2F88, 32'hCAFE_0001, 32'd0, 5);
    checkOutput("sw_latency", latency, 32'd7);
    checkOutput("sw_writes", wrCount, 32'd1);
    checkOutput("sw_reads", rdCount, 32'd0);
    checkOutput("sw_wdata", gotWdata, 32'hCAFE_0001);
    checkOutput("sw_addr_stable", addrBad, 32'd0);
    checkOutput("sw_tag", {11'd0, tagOut}, 32'h25);
    checkOutput("sw_index", {27'd0, indexOut}, 32'h1E);
    checkOutput("sw_offset", {26'd0, offsetOut}, 32'h08);
    checkOutput("sw_stall_cnt", {16'd0, stallCnt}, 32'd5);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 2);
    checkOutput("lw_stall_latency", latency, 32'd4);
    checkOutput("lw_stall_rdata", gotRdata, 32'hCAFE_F00D);
    checkOutput("lw_stall_cnt", {16'd0, stallCnt}, 32'd7);
    checkOutput("stall_cnt_model", {16'd0, stallCnt}, expStallCnt);

    // misaligned and illegal requests never touch the cache
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'd0, 32'h1234_5678, 0);
    checkOutput("lh_mis_latency", latency, 32'd1);
    checkOutput("lh_mis_err", {31'd0, gotErr}, 32'd1);
    checkOutput("lh_mis_rdata", gotRdata, 32'd0);
    checkOutput("lh_mis_strobes", rdCount + wrCount, 32'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'd7, 32'd0, 0);
    checkOutput("illegal_err", {31'd0, gotErr}, 32'd1);
    checkOutput("illegal_strobes", rdCount + wrCount, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'd0, 32'd0, 0);
    checkOutput("lw_mis_err", {31'd0, gotErr}, 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'd0, 32'h0000_7F00, 0);
    checkOutput("err_cleared", {31'd0, gotErr}, 32'd0);
    checkOutput("lb_pos", gotRdata, 32'h0000_007F);

    // reset asserted while an sh is in its read phase
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'b01; reqAddr = 32'h0000_0042; reqWdata = 32'h0000_1234;
    @(posedge clk);
    #1 reqValid = 1'b0; reqWe = 1'b0;
    @(negedge clk);
    checkOutput("mid_rd_strobe", {31'd0, readStrobe}, 32'd1);
    stallIn = 1'b1;
    nrst = 1'b1;
    #1;
    checkOutput("mid_rst_strobes", {30'd0, readStrobe, writeStrobe}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, reqReady}, 32'd1);
    checkOutput("mid_rst_stall_cnt", {16'd0, stallCnt}, 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    stallIn = 1'b0;
    wrCount = 0;
    latency = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (writeStrobe) wrCount++;
      if (respValid) latency++;
    end
    checkOutput("mid_rst_no_write", wrCount, 32'd0);
    checkOutput("mid_rst_no_resp", latency, 32'd0);
    checkOutput("mid_rst_ready_after", {31'd0, reqReady}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
